// File: rtl/ring_pkg.sv
// Ring slot field widths, slot-type codes and the slot record shared by ring clients.
package ring_pkg;
  localparam int DATA_W = 32;
  localparam int TYPE_W = 4;
  localparam int SRC_W  = 4;

  localparam logic [TYPE_W-1:0] SLOT_TOKEN = 4'd1;
  localparam logic [TYPE_W-1:0] SLOT_NULL  = 4'd7;
  localparam logic [TYPE_W-1:0] SLOT_MSG   = 4'd8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TYPE_W-1:0] stype;
    logic [SRC_W-1:0]  src;
  } slot_t;

  localparam slot_t SLOT_IDLE = '{data: 32'h0, stype: SLOT_NULL, src: 4'h0};
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot grant to the first requester after `last`, wrapping.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         gnt
);
  int idx;

  // Walk from farthest to nearest so the nearest pending requester overwrites.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) gnt = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    end
  end
endmodule

// File: rtl/ring_token_arbiter.sv
// Captures the ring token, hands it round-robin to local senders and muxes the
// owner's slot onto the registered ring output; passes the ring through otherwise.
module ring_token_arbiter
  import ring_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int MAX_GRANTS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SRC_W-1:0]       whichCore,
  input  logic [DATA_W-1:0]      RingIn,
  input  logic [TYPE_W-1:0]      SlotTypeIn,
  input  logic [SRC_W-1:0]       SourceIn,
  input  logic [NREQ-1:0]        want,
  input  logic [NREQ-1:0]        drive,
  input  logic [DATA_W*NREQ-1:0] reqRingOut,
  input  logic [TYPE_W*NREQ-1:0] reqSlotType,
  output logic [NREQ-1:0]        grant,
  output logic [DATA_W-1:0]      RingOut,
  output logic [TYPE_W-1:0]      SlotTypeOut,
  output logic [SRC_W-1:0]       SourceOut,
  output logic                   ringErr
);
  localparam int LW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_GRANTS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_GRANTS);
  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]    state, state_d;
  logic [LW-1:0] owner, owner_d, last, last_d, win;
  logic [CW-1:0] count, count_d;
  logic          err_d;
  logic [NREQ-1:0] pick_req, pick_gnt, owner_mask;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0][TYPE_W-1:0] req_type;
  slot_t slot_in, slot_q, slot_d, win_slot, own_slot, token_slot;

  assign req_data   = reqRingOut;
  assign req_type   = reqSlotType;
  assign slot_in    = '{data: RingIn, stype: SlotTypeIn, src: SourceIn};
  assign win_slot   = '{data: req_data[win], stype: req_type[win], src: whichCore};
  assign own_slot   = '{data: req_data[owner], stype: req_type[owner], src: whichCore};
  assign token_slot = '{data: '0, stype: SLOT_TOKEN, src: whichCore};

  always_comb begin
    owner_mask = '0;
    owner_mask[owner] = 1'b1;
  end

  // Hand-off candidates exclude the finishing owner; nothing is offered once the cap is hit.
  always_comb begin
    pick_req = '0;
    if (state == ST_PASS) begin
      if (SlotTypeIn == SLOT_TOKEN) pick_req = want;
    end else if (!drive[owner] && count < CNT_MAX) begin
      pick_req = want & ~owner_mask;
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (pick_req),
    .last (last),
    .gnt  (pick_gnt)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_gnt[i]) win = LW'(i);
  end

  assign grant = reset ? pick_gnt : '0;

  always_comb begin
    slot_d  = slot_in;
    state_d = state;
    owner_d = owner;
    count_d = count;
    last_d  = last;
    err_d   = 1'b0;
    if (state == ST_PASS) begin
      if (|pick_gnt) begin
        last_d = win;
        if (drive[win]) begin
          slot_d  = win_slot;
          owner_d = win;
          count_d = CW'(1);
          state_d = ST_OWN;
        end
      end
    end else begin
      err_d = (SlotTypeIn != SLOT_NULL);
      if (drive[owner]) begin
        slot_d = own_slot;
      end else if (|pick_gnt) begin
        last_d = win;
        if (drive[win]) begin
          slot_d  = win_slot;
          owner_d = win;
          count_d = count + CW'(1);
        end else begin
          slot_d  = token_slot;
          state_d = ST_PASS;
        end
      end else begin
        slot_d  = token_slot;
        state_d = ST_PASS;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_PASS;
      owner   <= '0;
      last    <= LW'(NREQ - 1);
      count   <= '0;
      slot_q  <= SLOT_IDLE;
      ringErr <= 1'b0;
    end else begin
      state   <= state_d;
      owner   <= owner_d;
      last    <= last_d;
      count   <= count_d;
      slot_q  <= slot_d;
      ringErr <= err_d;
    end
  end

  assign RingOut     = slot_q.data;
  assign SlotTypeOut = slot_q.stype;
  assign SourceOut   = slot_q.src;
endmodule

// File: tb/tb_ring_token_arbiter.sv
// Randomized bench for ring_token_arbiter against a rule-level token-ownership model.
module tb_ring_token_arbiter;
  localparam int N    = 4;
  localparam int MAXG = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0]      whichCore = 4'h5;
  logic [31:0]     RingIn = '0;
  logic [3:0]      SlotTypeIn = 4'd7;
  logic [3:0]      SourceIn = '0;
  logic [N-1:0]    want = '0, drive = '0, grant;
  logic [32*N-1:0] reqRingOut = '0;
  logic [4*N-1:0]  reqSlotType = '0;
  logic [31:0]     RingOut;
  logic [3:0]      SlotTypeOut, SourceOut;
  logic            ringErr;

  ring_token_arbiter #(.NREQ(N), .MAX_GRANTS(MAXG)) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .want(want), .drive(drive), .reqRingOut(reqRingOut), .reqSlotType(reqSlotType),
    .grant(grant), .RingOut(RingOut), .SlotTypeOut(SlotTypeOut),
    .SourceOut(SourceOut), .ringErr(ringErr)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of token ownership.
  bit held = 0;
  int owner = 0, last = N-1, count = 0;
  // Requester behaviour.
  bit rq_want[N], rq_acc[N];
  int rq_burst[N], rq_cool[N];
  int blen = 0;
  int glog[$];

  function automatic int pick(logic [N-1:0] r, int from);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return 0;
  endfunction

  task automatic step(input logic [3:0] st, input logic [31:0] d, input bit rst_n, input bit autoreq);
    logic [N-1:0] eg, oth;
    logic [31:0] od;
    logic [3:0] ot, os;
    bit oe;
    int w;
    @(negedge clock);
    reset = rst_n;
    SlotTypeIn = st;
    RingIn = d;
    SourceIn = 4'($urandom);
    for (int i = 0; i < N; i++) begin
      want[i]  = rq_want[i];
      drive[i] = (rq_burst[i] > 0) || (rq_want[i] && rq_acc[i]);
      reqRingOut[32*i +: 32] = $urandom;
      reqSlotType[4*i +: 4]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd8;
    end
    #1;
    eg = '0; od = d; ot = st; os = SourceIn; oe = 0;
    if (!rst_n) begin
      od = 0; ot = 4'd7; os = 0;
      held = 0; last = N-1; count = 0;
    end else if (!held) begin
      if (st == 4'd1 && want != 0) begin
        w = pick(want, last); eg[w] = 1'b1; last = w;
        if (drive[w]) begin
          od = reqRingOut[32*w +: 32]; ot = reqSlotType[4*w +: 4]; os = whichCore;
          held = 1; owner = w; count = 1;
        end
      end
    end else begin
      oe = (st != 4'd7);
      if (drive[owner]) begin
        od = reqRingOut[32*owner +: 32]; ot = reqSlotType[4*owner +: 4]; os = whichCore;
      end else begin
        oth = want; oth[owner] = 1'b0;
        if (count < MAXG && oth != 0) begin
          w = pick(oth, last); eg[w] = 1'b1; last = w;
          if (drive[w]) begin
            od = reqRingOut[32*w +: 32]; ot = reqSlotType[4*w +: 4]; os = whichCore;
            owner = w; count++;
          end else begin
            od = 0; ot = 4'd1; os = whichCore; held = 0;
          end
        end else begin
          od = 0; ot = 4'd1; os = whichCore; held = 0;
        end
      end
    end
    chk("grant", grant, eg);
    for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
    @(posedge clock);
    #1;
    chk("RingOut", RingOut, od);
    chk("SlotTypeOut", SlotTypeOut, ot);
    chk("SourceOut", SourceOut, os);
    chk("ringErr", ringErr, oe);
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        rq_want[i] = 0; rq_burst[i] = 0; rq_cool[i] = 0;
      end else begin
        if (rq_burst[i] > 0) rq_burst[i]--;
        if (eg[i]) begin
          rq_want[i] = 0; rq_cool[i] = 3;
          if (rq_acc[i]) rq_burst[i] = ((blen > 0) ? blen : int'($urandom_range(1, 4))) - 1;
        end else if (autoreq && !rq_want[i] && rq_burst[i] == 0) begin
          if (rq_cool[i] > 0) rq_cool[i]--;
          else if ($urandom_range(0, 3) == 0) begin
            rq_want[i] = 1; rq_acc[i] = ($urandom_range(0, 9) != 0);
          end
        end
      end
    end
  endtask

  initial begin
    int r;
    logic [3:0] st;
    for (int i = 0; i < N; i++) begin
      rq_want[i] = 0; rq_acc[i] = 0; rq_burst[i] = 0; rq_cool[i] = 0;
    end
    step(4'd7, 32'h0, 0, 0);
    step(4'd7, 32'h0, 0, 0);
    // Plain pass-through of a message slot.
    step(4'd8, 32'h0001_2345, 1, 0);
    // Requester 1 is offered the token but declines it.
    rq_want[1] = 1; rq_acc[1] = 0;
    step(4'd1, 32'h0, 1, 0);
    step(4'd7, 32'h0, 1, 0);
    // All four requesters want: grant cap forces token re-emission after four bursts.
    step(4'd7, 32'h0, 0, 0);
    for (int i = 0; i < N; i++) begin
      rq_want[i] = 1; rq_acc[i] = 1; rq_cool[i] = 0;
    end
    blen = 2;
    glog.delete();
    step(4'd1, 32'h0, 1, 0);
    for (int c = 0; c < 14; c++)
      step((c == 2) ? 4'd8 : 4'd7, 32'hdead_0000 + c, 1, 0);
    chk("cap_grants", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) chk("cap_order", glog[k], k);
    // Random traffic with occasional resets.
    blen = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      if (r < 3) st = 4'd1;
      else if (r < 7) st = 4'd7;
      else if (r < 9) st = 4'd8;
      else st = 4'($urandom);
      step(st, $urandom, $urandom_range(0, 199) != 0, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
